// File: rtl/mc_mem_seq.sv
// -----------------------------------------------------------------------------
// mc_mem_seq -- single-port memory access sequencer for the multicycle CPU
//
// Holds one pending instruction fetch and one pending data access, and
// serialises them onto one memory port with a req/ready handshake. A pending
// data access is always served before a pending fetch. Fetched instructions
// and load data are returned with one-cycle valid pulses. Stores are returned
// with a one-cycle done pulse. An access that waits too long for mem_ready is
// aborted by a timeout.
//
// Ports
//   clk, rst                  clock (rising edge), asynchronous active-low reset
//   fetch_req/fetch_addr      fetch request pulse and instruction address
//   data_req/data_we/
//   data_addr/data_wdata      data request pulse, store flag, address, store data
//   mem_req/mem_we/mem_addr/
//   mem_wdata                 memory request; attributes are registered and held
//   mem_ready/mem_rdata       memory completion strobe and read data
//   instr/instr_valid         last fetched instruction and its update pulse
//   rdata/rdata_valid         last load data and its update pulse
//   wr_done                   store completion pulse
//   stall                     a slot is pending or an access is in flight
//   drop_err                  request ignored because its slot was occupied
//   tmo_err                   access aborted by the timeout
// -----------------------------------------------------------------------------
module mc_mem_seq #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16,
    parameter int TW      = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fetch_req,
    input  logic [AW-1:0] fetch_addr,
    input  logic          data_req,
    input  logic          data_we,
    input  logic [AW-1:0] data_addr,
    input  logic [DW-1:0] data_wdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ready,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] instr,
    output logic          instr_valid,
    output logic [DW-1:0] rdata,
    output logic          rdata_valid,
    output logic          wr_done,
    output logic          stall,
    output logic          drop_err,
    output logic          tmo_err
);

    // Byte-offset bits inside one data word are forced to zero on mem_addr.
    localparam int            AL         = $clog2(DW / 8);
    localparam logic [AW-1:0] ALIGN_MASK = ~((AW'(1) << AL) - AW'(1));

    typedef enum logic {S_IDLE, S_ACCESS} state_t;

    state_t        state_q, state_d;
    logic          fslot_full_q, fslot_full_d;
    logic [AW-1:0] fslot_addr_q, fslot_addr_d;
    logic          dslot_full_q, dslot_full_d;
    logic          dslot_we_q, dslot_we_d;
    logic [AW-1:0] dslot_addr_q, dslot_addr_d;
    logic [DW-1:0] dslot_wdata_q, dslot_wdata_d;
    logic          cur_data_q, cur_data_d;     // access in flight serves the data slot
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] instr_q, instr_d;
    logic          instr_valid_q, instr_valid_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          rdata_valid_q, rdata_valid_d;
    logic          wr_done_q, wr_done_d;
    logic          drop_err_q, drop_err_d;
    logic          tmo_err_q, tmo_err_d;
    logic          tmo_hit;

    assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt_q == TW'(TIMEOUT - 1));

    always_comb begin
        state_d       = state_q;
        fslot_full_d  = fslot_full_q;
        fslot_addr_d  = fslot_addr_q;
        dslot_full_d  = dslot_full_q;
        dslot_we_d    = dslot_we_q;
        dslot_addr_d  = dslot_addr_q;
        dslot_wdata_d = dslot_wdata_q;
        cur_data_d    = cur_data_q;
        tmo_cnt_d     = tmo_cnt_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        instr_d       = instr_q;
        rdata_d       = rdata_q;
        instr_valid_d = 1'b0;
        rdata_valid_d = 1'b0;
        wr_done_d     = 1'b0;
        tmo_err_d     = 1'b0;

        // A slot stays full until its access completes, so a request arriving
        // in the completion cycle is dropped as well.
        drop_err_d = (fetch_req & fslot_full_q) | (data_req & dslot_full_q);

        if (fetch_req && !fslot_full_q) begin
            fslot_full_d = 1'b1;
            fslot_addr_d = fetch_addr;
        end
        if (data_req && !dslot_full_q) begin
            dslot_full_d  = 1'b1;
            dslot_we_d    = data_we;
            dslot_addr_d  = data_addr;
            dslot_wdata_d = data_wdata;
        end

        case (state_q)
            S_IDLE: begin
                // Selection looks at the post-edge slot contents, so a request
                // into an idle sequencer starts its access at the same edge.
                if (dslot_full_d) begin
                    state_d     = S_ACCESS;
                    cur_data_d  = 1'b1;
                    tmo_cnt_d   = '0;
                    mem_we_d    = dslot_we_d;
                    mem_addr_d  = dslot_addr_d & ALIGN_MASK;
                    mem_wdata_d = dslot_wdata_d;
                end else if (fslot_full_d) begin
                    state_d    = S_ACCESS;
                    cur_data_d = 1'b0;
                    tmo_cnt_d  = '0;
                    mem_we_d   = 1'b0;
                    mem_addr_d = fslot_addr_d & ALIGN_MASK;
                end
            end
            S_ACCESS: begin
                if (mem_ready) begin
                    state_d = S_IDLE;
                    if (cur_data_q) begin
                        dslot_full_d = 1'b0;
                        if (mem_we_q) begin
                            wr_done_d = 1'b1;
                        end else begin
                            rdata_d       = mem_rdata;
                            rdata_valid_d = 1'b1;
                        end
                    end else begin
                        fslot_full_d  = 1'b0;
                        instr_d       = mem_rdata;
                        instr_valid_d = 1'b1;
                    end
                end else if (tmo_hit) begin
                    state_d   = S_IDLE;
                    tmo_err_d = 1'b1;
                    if (cur_data_q) dslot_full_d = 1'b0;
                    else            fslot_full_d = 1'b0;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            fslot_full_q  <= 1'b0;
            fslot_addr_q  <= '0;
            dslot_full_q  <= 1'b0;
            dslot_we_q    <= 1'b0;
            dslot_addr_q  <= '0;
            dslot_wdata_q <= '0;
            cur_data_q    <= 1'b0;
            tmo_cnt_q     <= '0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            wr_done_q     <= 1'b0;
            drop_err_q    <= 1'b0;
            tmo_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            fslot_full_q  <= fslot_full_d;
            fslot_addr_q  <= fslot_addr_d;
            dslot_full_q  <= dslot_full_d;
            dslot_we_q    <= dslot_we_d;
            dslot_addr_q  <= dslot_addr_d;
            dslot_wdata_q <= dslot_wdata_d;
            cur_data_q    <= cur_data_d;
            tmo_cnt_q     <= tmo_cnt_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            wr_done_q     <= wr_done_d;
            drop_err_q    <= drop_err_d;
            tmo_err_q     <= tmo_err_d;
        end
    end

    // mem_req decodes the state flop directly so reset drops it at once.
    assign mem_req     = (state_q == S_ACCESS);
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign wr_done     = wr_done_q;
    assign drop_err    = drop_err_q;
    assign tmo_err     = tmo_err_q;
    assign stall       = fslot_full_q | dslot_full_q | (state_q != S_IDLE);

endmodule

// File: tb/tb_mc_mem_seq.sv
// -----------------------------------------------------------------------------
// tb_mc_mem_seq -- directed testbench for mc_mem_seq
//
// A table of per-cycle vectors covers single fetch, load-before-fetch ordering,
// a store held through wait states and dropped requests. Hand-written sequences
// cover the timeout abort and an asynchronous reset in the middle of an access.
// Each vector gives the inputs for one clock cycle and the outputs expected
// just after the following rising edge.
// -----------------------------------------------------------------------------
module tb_mc_mem_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch_req = 1'b0;
    logic [31:0] fetch_addr = '0;
    logic        data_req = 1'b0;
    logic        data_we = 1'b0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] instr, rdata;
    logic        instr_valid, rdata_valid, wr_done, stall, drop_err, tmo_err;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mc_mem_seq #(.AW(32), .DW(32), .TIMEOUT(16), .TW(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .data_req   (data_req),
        .data_we    (data_we),
        .data_addr  (data_addr),
        .data_wdata (data_wdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .instr      (instr),
        .instr_valid(instr_valid),
        .rdata      (rdata),
        .rdata_valid(rdata_valid),
        .wr_done    (wr_done),
        .stall      (stall),
        .drop_err   (drop_err),
        .tmo_err    (tmo_err)
    );

    // flags: {mem_req, mem_we, instr_valid, rdata_valid, wr_done, stall, drop_err, tmo_err}
    typedef struct {
        logic        fr;
        logic [31:0] fa;
        logic        dr;
        logic        dw;
        logic [31:0] da;
        logic [31:0] wd;
        logic        rdy;
        logic [31:0] rd;
        logic [7:0]  ef;
        logic [31:0] ea;
        logic [31:0] ewd;
        logic [31:0] ei;
        logic [31:0] erd;
    } vec_t;

    localparam int NV = 26;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic fr, input logic [31:0] fa,
                                input logic dr, input logic dw, input logic [31:0] da,
                                input logic [31:0] wd, input logic rdy, input logic [31:0] rd,
                                input logic [7:0] ef, input logic [31:0] ea,
                                input logic [31:0] ewd, input logic [31:0] ei,
                                input logic [31:0] erd);
        vec_t v;
        v.fr = fr;  v.fa = fa;  v.dr = dr;  v.dw = dw;  v.da = da;  v.wd = wd;
        v.rdy = rdy; v.rd = rd; v.ef = ef;  v.ea = ea;  v.ewd = ewd;
        v.ei = ei;  v.erd = erd;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mem_we/mem_addr are only meaningful while mem_req is high, and
    // mem_wdata only for a store.
    task automatic check(input string name, input logic [7:0] ef, input logic [31:0] ea,
                         input logic [31:0] ewd, input logic [31:0] ei, input logic [31:0] erd);
        logic [7:0] af;
        logic       bad;
        af  = {mem_req, mem_req & mem_we, instr_valid, rdata_valid, wr_done,
               stall, drop_err, tmo_err};
        bad = (af !== ef) || (instr !== ei) || (rdata !== erd);
        if (ef[7] && (mem_addr !== ea)) bad = 1'b1;
        if (ef[7] && ef[6] && (mem_wdata !== ewd)) bad = 1'b1;
        n_vec++;
        if (bad) begin
            n_bad++;
            $display("FAIL %s: got flags=%b addr=%h wdata=%h instr=%h rdata=%h, want flags=%b addr=%h wdata=%h instr=%h rdata=%h",
                     name, af, mem_addr, mem_wdata, instr, rdata, ef, ea, ewd, ei, erd);
        end else begin
            $display("ok   %s: flags=%b addr=%h instr=%h rdata=%h", name, af, mem_addr, instr, rdata);
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    initial begin
        int req_cycles;
        int tmo_pulses;
        int iv_pulses;

        // Test 1: single fetch, memory ready immediately
        vecs[0]  = mk(1, 32'h40,  0, 0, 0, 0, 1, 32'h2002_0005, 8'b1000_0100, 32'h40,  0, 0, 0);
        vecs[1]  = mk(0, 0,       0, 0, 0, 0, 1, 32'h2002_0005, 8'b0010_0000, 0,       0, 32'h2002_0005, 0);
        vecs[2]  = mk(0, 0,       0, 0, 0, 0, 1, 32'hFFFF_FFFF, 8'b0000_0000, 0,       0, 32'h2002_0005, 0);
        // Test 2: fetch and load together, two wait states each; load first
        vecs[3]  = mk(1, 32'h200, 1, 0, 32'h100, 0, 0, 0, 8'b1000_0100, 32'h100, 0, 32'h2002_0005, 0);
        vecs[4]  = mk(0, 0,       0, 0, 0, 0, 0, 0,             8'b1000_0100, 32'h100, 0, 32'h2002_0005, 0);
        vecs[5]  = mk(0, 0,       0, 0, 0, 0, 0, 0,             8'b1000_0100, 32'h100, 0, 32'h2002_0005, 0);
        vecs[6]  = mk(0, 0,       0, 0, 0, 0, 1, 32'h1111_2222, 8'b0001_0100, 0,       0, 32'h2002_0005, 32'h1111_2222);
        vecs[7]  = mk(0, 0,       0, 0, 0, 0, 0, 0,             8'b1000_0100, 32'h200, 0, 32'h2002_0005, 32'h1111_2222);
        vecs[8]  = mk(0, 0,       0, 0, 0, 0, 0, 0,             8'b1000_0100, 32'h200, 0, 32'h2002_0005, 32'h1111_2222);
        vecs[9]  = mk(0, 0,       0, 0, 0, 0, 0, 0,             8'b1000_0100, 32'h200, 0, 32'h2002_0005, 32'h1111_2222);
        vecs[10] = mk(0, 0,       0, 0, 0, 0, 1, 32'h3333_4444, 8'b0010_0000, 0,       0, 32'h3333_4444, 32'h1111_2222);
        vecs[11] = mk(0, 0,       0, 0, 0, 0, 0, 0,             8'b0000_0000, 0,       0, 32'h3333_4444, 32'h1111_2222);
        // Test 3: unaligned store, three wait states, wdata input changes meanwhile
        vecs[12] = mk(0, 0, 1, 1, 32'h103, 32'hDEAD_BEEF, 0, 0, 8'b1100_0100, 32'h100, 32'hDEAD_BEEF, 32'h3333_4444, 32'h1111_2222);
        vecs[13] = mk(0, 0, 0, 0, 0, 32'h0BAD_F00D, 0, 0,      8'b1100_0100, 32'h100, 32'hDEAD_BEEF, 32'h3333_4444, 32'h1111_2222);
        vecs[14] = mk(0, 0, 0, 0, 0, 32'h0BAD_F00D, 0, 0,      8'b1100_0100, 32'h100, 32'hDEAD_BEEF, 32'h3333_4444, 32'h1111_2222);
        vecs[15] = mk(0, 0, 0, 0, 0, 32'h0BAD_F00D, 0, 0,      8'b1100_0100, 32'h100, 32'hDEAD_BEEF, 32'h3333_4444, 32'h1111_2222);
        vecs[16] = mk(0, 0, 0, 0, 0, 0, 1, 32'h1234_5678,      8'b0000_1000, 0,       0, 32'h3333_4444, 32'h1111_2222);
        vecs[17] = mk(0, 0, 0, 0, 0, 0, 0, 0,                  8'b0000_0000, 0,       0, 32'h3333_4444, 32'h1111_2222);
        // Test 5: second fetch while the first waits is dropped
        vecs[18] = mk(1, 32'h300, 0, 0, 0, 0, 0, 0,            8'b1000_0100, 32'h300, 0, 32'h3333_4444, 32'h1111_2222);
        vecs[19] = mk(1, 32'h304, 0, 0, 0, 0, 0, 0,            8'b1000_0110, 32'h300, 0, 32'h3333_4444, 32'h1111_2222);
        vecs[20] = mk(0, 0,       0, 0, 0, 0, 0, 0,            8'b1000_0100, 32'h300, 0, 32'h3333_4444, 32'h1111_2222);
        vecs[21] = mk(0, 0,       0, 0, 0, 0, 1, 32'h5555_6666, 8'b0010_0000, 0,      0, 32'h5555_6666, 32'h1111_2222);
        vecs[22] = mk(0, 0,       0, 0, 0, 0, 0, 0,            8'b0000_0000, 0,       0, 32'h5555_6666, 32'h1111_2222);
        // Request in the same cycle its slot completes is dropped
        vecs[23] = mk(1, 32'h400, 0, 0, 0, 0, 0, 0,            8'b1000_0100, 32'h400, 0, 32'h5555_6666, 32'h1111_2222);
        vecs[24] = mk(1, 32'h404, 0, 0, 0, 0, 1, 32'h77,       8'b0010_0010, 0,       0, 32'h77, 32'h1111_2222);
        vecs[25] = mk(0, 0,       0, 0, 0, 0, 0, 0,            8'b0000_0000, 0,       0, 32'h77, 32'h1111_2222);

        // Reset state
        #12;
        check("reset_state", 8'b0000_0000, 0, 0, 0, 0);
        step();
        rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            fetch_req  = vecs[i].fr;
            fetch_addr = vecs[i].fa;
            data_req   = vecs[i].dr;
            data_we    = vecs[i].dw;
            data_addr  = vecs[i].da;
            data_wdata = vecs[i].wd;
            mem_ready  = vecs[i].rdy;
            mem_rdata  = vecs[i].rd;
            step();
            check($sformatf("vec%0d", i), vecs[i].ef, vecs[i].ea, vecs[i].ewd,
                  vecs[i].ei, vecs[i].erd);
        end
        fetch_req = 1'b0;
        data_req  = 1'b0;

        // Test 4: timeout with mem_ready held low
        fetch_req  = 1'b1;
        fetch_addr = 32'h500;
        mem_ready  = 1'b0;
        step();
        fetch_req  = 1'b0;
        req_cycles = mem_req ? 1 : 0;
        tmo_pulses = 0;
        iv_pulses  = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (mem_req)     req_cycles++;
            if (tmo_err)     tmo_pulses++;
            if (instr_valid) iv_pulses++;
        end
        check_val("tmo_req_cycles", req_cycles, 16);
        check_val("tmo_err_pulses", tmo_pulses, 1);
        check_val("tmo_instr_valid", iv_pulses, 0);
        check("tmo_idle", 8'b0000_0000, 0, 0, 32'h77, 32'h1111_2222);

        data_req  = 1'b1;
        data_we   = 1'b0;
        data_addr = 32'h600;
        mem_ready = 1'b1;
        mem_rdata = 32'h99;
        step();
        data_req  = 1'b0;
        check("tmo_next_issue", 8'b1000_0100, 32'h600, 0, 32'h77, 32'h1111_2222);
        step();
        mem_ready = 1'b0;
        check("tmo_next_done", 8'b0001_0000, 0, 0, 32'h77, 32'h99);

        // Test 6: asynchronous reset during a wait state
        fetch_req  = 1'b1;
        fetch_addr = 32'h700;
        step();
        fetch_req  = 1'b0;
        check("rst_issue", 8'b1000_0100, 32'h700, 0, 32'h77, 32'h99);
        step();
        #3;
        rst = 1'b0;
        #1;
        check("rst_async", 8'b0000_0000, 0, 0, 0, 0);
        mem_ready = 1'b1;
        mem_rdata = 32'hAA;
        step();
        step();
        rst = 1'b1;
        step();
        check("rst_release0", 8'b0000_0000, 0, 0, 0, 0);
        step();
        check("rst_release1", 8'b0000_0000, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
